// File: rtl/key_step_conditioner.sv
// Push-button synchroniser/debouncer with a glitch-free single-step clock
// and optional auto-repeat derived from key 0.
module key_step_conditioner #(
  parameter int unsigned NKEYS         = 4,
  parameter int unsigned DEB_CYCLES    = 1000000,
  parameter int unsigned STEP_WIDTH    = 8,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic             CLOCK_50,
  input  logic             SYS_rst,
  input  logic [NKEYS-1:0] key_n,
  input  logic             step_en,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic             step_clk,
  output logic [15:0]      step_count
);

  localparam int unsigned DW     = $clog2(DEB_CYCLES);
  localparam int unsigned TMAX_A = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TMAX   = (TMAX_A > STEP_WIDTH) ? TMAX_A : STEP_WIDTH;
  localparam int unsigned TW     = $clog2(TMAX) + 1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PULSE       = 2'd1,
    WAIT_DELAY  = 2'd2,
    WAIT_PERIOD = 2'd3
  } state_e;

  logic [NKEYS-1:0]         sync1_q, sync2_q;
  logic [NKEYS-1:0]         level_q, level_d;
  logic [NKEYS-1:0]         press_q, press_d;
  logic [NKEYS-1:0]         release_q, release_d;
  logic [NKEYS-1:0][DW-1:0] cnt_q, cnt_d;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          first_q, first_d;
  logic          step_clk_q, step_clk_d;
  logic [15:0]   step_count_q, step_count_d;
  logic          hold_ok;

  always_ff @(posedge CLOCK_50) begin
    if (!SYS_rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      press_q      <= '0;
      release_q    <= '0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      tmr_q        <= '0;
      first_q      <= 1'b0;
      step_clk_q   <= 1'b1;
      step_count_q <= '0;
    end else begin
      sync1_q      <= ~key_n;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      first_q      <= first_d;
      step_clk_q   <= step_clk_d;
      step_count_q <= step_count_d;
    end
  end

  // Debounce: accept a change only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    cnt_d     = cnt_q;
    for (int i = 0; i < int'(NKEYS); i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
        cnt_d[i]     = '0;
        level_d[i]   = ~level_q[i];
        press_d[i]   = ~level_q[i];
        release_d[i] = level_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  assign hold_ok = level_q[0] && step_en;

  // Step FSM: one pulse per press, then optional delayed auto-repeat while held.
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    first_d      = first_q;
    step_count_d = step_count_q;
    case (state_q)
      IDLE: begin
        if (press_q[0]) begin
          state_d = PULSE;
          first_d = 1'b1;
          tmr_d   = '0;
        end
      end
      PULSE: begin
        if (tmr_q == TW'(STEP_WIDTH - 1)) begin
          tmr_d        = '0;
          step_count_d = step_count_q + 16'd1;
          if (hold_ok) state_d = first_q ? WAIT_DELAY : WAIT_PERIOD;
          else         state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      WAIT_DELAY, WAIT_PERIOD: begin
        if (!hold_ok) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if ((state_q == WAIT_DELAY  && tmr_q == TW'(REPEAT_DELAY - 1)) ||
                     (state_q == WAIT_PERIOD && tmr_q == TW'(REPEAT_PERIOD - 1))) begin
          state_d = PULSE;
          first_d = 1'b0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
    step_clk_d = (state_d != PULSE);
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign step_clk    = step_clk_q;
  assign step_count  = step_count_q;

endmodule

// File: tb/tb_key_step_conditioner.sv
// Directed bench for key_step_conditioner with short debounce/step/repeat timings.
module tb_key_step_conditioner;

  logic        clk = 1'b0;
  logic        SYS_rst;
  logic [3:0]  key_n;
  logic        step_en;
  logic [3:0]  key_level, key_press, key_release;
  logic        step_clk;
  logic [15:0] step_count;

  always #5 clk = ~clk;

  key_step_conditioner #(
    .NKEYS(4), .DEB_CYCLES(4), .STEP_WIDTH(2), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut (
    .CLOCK_50(clk), .SYS_rst(SYS_rst), .key_n(key_n), .step_en(step_en),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .step_clk(step_clk), .step_count(step_count)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Per-window observation statistics, edge index starts at 0.
  int   cyc, npress0, press0_at, nrel0, npress1, nrel1, lvl1_seen, nfall, nrise, nlow;
  int   fall_at [16];
  int   rise_at [16];
  logic prev_sc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  task automatic clear_stats();
    cyc = 0; npress0 = 0; press0_at = -1; nrel0 = 0; npress1 = 0; nrel1 = 0;
    lvl1_seen = 0; nfall = 0; nrise = 0; nlow = 0;
    for (int i = 0; i < 16; i++) begin
      fall_at[i] = -1;
      rise_at[i] = -1;
    end
    prev_sc = step_clk;
  endtask

  task automatic step_cycle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (key_press[0]) begin
        if (npress0 == 0) press0_at = cyc;
        npress0++;
      end
      if (key_release[0]) nrel0++;
      if (key_press[1]) npress1++;
      if (key_release[1]) nrel1++;
      if (key_level[1]) lvl1_seen = 1;
      if (!step_clk) nlow++;
      if (prev_sc && !step_clk) begin
        if (nfall < 16) fall_at[nfall] = cyc;
        nfall++;
      end
      if (!prev_sc && step_clk) begin
        if (nrise < 16) rise_at[nrise] = cyc;
        nrise++;
      end
      prev_sc = step_clk;
      cyc++;
    end
  endtask

  initial begin
    SYS_rst = 1'b0;
    key_n   = 4'hF;
    step_en = 1'b0;
    @(negedge clk);
    step_cycle(3);
    chk("rst_level",   32'(key_level),   32'h0);
    chk("rst_press",   32'(key_press),   32'h0);
    chk("rst_release", 32'(key_release), 32'h0);
    chk("rst_stepclk", 32'(step_clk),    32'h1);
    chk("rst_count",   32'(step_count),  32'h0);
    SYS_rst = 1'b1;
    step_cycle(3);

    // Clean press, step_en off
    clear_stats();
    key_n[0] = 1'b0;
    step_cycle(20);
    chk("clean_npress",   32'(npress0),    32'd1);
    chk("clean_press_at", 32'(press0_at),  32'd5);
    chk("clean_fall_at",  32'(fall_at[0]), 32'd6);
    chk("clean_rise_at",  32'(rise_at[0]), 32'd8);
    chk("clean_nlow",     32'(nlow),       32'd2);
    chk("clean_count",    32'(step_count), 32'd1);
    chk("clean_level",    32'(key_level),  32'h1);
    clear_stats();
    key_n[0] = 1'b1;
    step_cycle(20);
    chk("rel_nrel",  32'(nrel0),      32'd1);
    chk("rel_nfall", 32'(nfall),      32'd0);
    chk("rel_level", 32'(key_level),  32'h0);
    chk("rel_count", 32'(step_count), 32'd1);

    // Bounce on key 1: 3-cycle runs never reach the 4-sample threshold
    clear_stats();
    for (int j = 0; j < 10; j++) begin
      key_n[1] = ~key_n[1];
      step_cycle(3);
    end
    key_n[1] = 1'b1;
    step_cycle(10);
    chk("bounce_level", 32'(lvl1_seen), 32'd0);
    chk("bounce_press", 32'(npress1),   32'd0);
    chk("bounce_rel",   32'(nrel1),     32'd0);
    chk("bounce_fall",  32'(nfall),     32'd0);

    // Auto-repeat: falls expected at 6,18,25,32, rises at 8,20,27,34
    step_en = 1'b1;
    clear_stats();
    key_n[0] = 1'b0;
    step_cycle(36);
    step_en = 1'b0;
    step_cycle(5);
    step_en = 1'b1;
    step_cycle(20);
    chk("ar_nfall",   32'(nfall),                    32'd4);
    chk("ar_nrise",   32'(nrise),                    32'd4);
    chk("ar_fall0",   32'(fall_at[0]),               32'd6);
    chk("ar_width0",  32'(rise_at[0] - fall_at[0]),  32'd2);
    chk("ar_gap1",    32'(fall_at[1] - rise_at[0]),  32'd10);
    chk("ar_gap2",    32'(fall_at[2] - rise_at[1]),  32'd5);
    chk("ar_gap3",    32'(fall_at[3] - rise_at[2]),  32'd5);
    chk("ar_width3",  32'(rise_at[3] - fall_at[3]),  32'd2);
    chk("ar_count",   32'(step_count),               32'd5);
    chk("ar_stepclk", 32'(step_clk),                 32'h1);
    step_en = 1'b0;
    key_n[0] = 1'b1;
    step_cycle(20);
    chk("ar_after_level", 32'(key_level), 32'h0);

    // Short tap with step_en off: release raw key right after the fall
    clear_stats();
    key_n[0] = 1'b0;
    step_cycle(7);
    key_n[0] = 1'b1;
    step_cycle(25);
    chk("tapA_nfall", 32'(nfall),      32'd1);
    chk("tapA_nlow",  32'(nlow),       32'd2);
    chk("tapA_count", 32'(step_count), 32'd6);

    // Short tap with step_en on: level drops during the delay wait, no repeat
    step_en = 1'b1;
    clear_stats();
    key_n[0] = 1'b0;
    step_cycle(7);
    key_n[0] = 1'b1;
    step_cycle(30);
    chk("tapB_nfall", 32'(nfall),      32'd1);
    chk("tapB_nlow",  32'(nlow),       32'd2);
    chk("tapB_count", 32'(step_count), 32'd7);
    step_en = 1'b0;

    // Reset mid-pulse
    clear_stats();
    key_n[0] = 1'b0;
    step_cycle(7);
    chk("rmp_pre_low", 32'(step_clk), 32'h0);
    SYS_rst = 1'b0;
    key_n   = 4'hF;
    step_cycle(1);
    chk("rmp_stepclk", 32'(step_clk),   32'h1);
    chk("rmp_count",   32'(step_count), 32'h0);
    chk("rmp_level",   32'(key_level),  32'h0);
    SYS_rst = 1'b1;
    clear_stats();
    step_cycle(20);
    chk("rmp_nfall",  32'(nfall),   32'd0);
    chk("rmp_npress", 32'(npress0), 32'd0);

    // Counter wrap
    force dut.step_count_q = 16'hFFFF;
    step_cycle(1);
    release dut.step_count_q;
    step_cycle(1);
    chk("wrap_pre", 32'(step_count), 32'hFFFF);
    clear_stats();
    key_n[0] = 1'b0;
    step_cycle(10);
    key_n[0] = 1'b1;
    step_cycle(20);
    chk("wrap_nfall", 32'(nfall),      32'd1);
    chk("wrap_count", 32'(step_count), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
